// File: rtl/dmni_tx_arbiter_pkg.sv
// Shared types and helpers for the DMNI local-port packet arbiter.
package dmni_tx_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int N_REQ_MAX = 8;
  localparam int STAT_W    = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmni_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping at N_REQ.
module dmni_tx_arbiter_rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [PTR_W-1:0] idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  int j;

  // Walk offsets from farthest to nearest so the nearest pending request wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    j        = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = PTR_W'(j);
      end
    end
    if (valid_o) onehot_o = N_REQ'(1) << idx_o;
  end

endmodule

// File: rtl/dmni_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC injection port among N_REQ requesters.
// Optional statistics counters are enabled with `define DMNI_ARB_STATS_EN.
module dmni_tx_arbiter
  import dmni_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int FLIT_SIZE = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_tx_i,
  input  logic [N_REQ-1:0]           req_eop_i,
  input  logic [N_REQ*FLIT_SIZE-1:0] req_data_i,
  output logic [N_REQ-1:0]           req_credit_o,
  output logic                       tx_o,
  output logic                       eop_o,
  output logic [FLIT_SIZE-1:0]       data_o,
  input  logic                       credit_i,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       busy_o
`ifdef DMNI_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]    pkt_cnt_o,
  output logic [STAT_W-1:0]          stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;
  logic             eop_xfer;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  dmni_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i    (req_tx_i),
    .ptr_i    (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Outputs are forced low while reset is asserted, even with requests pending.
  always_comb begin
    gnt_vld      = rst_ni && ((state_q == HOLD) || pick_valid);
    gnt_idx      = (state_q == HOLD) ? gnt_q : pick_idx;
    grant_o      = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
    busy_o       = rst_ni && (state_q == HOLD);
    tx_o         = gnt_vld && req_tx_i[gnt_idx];
    eop_o        = tx_o && req_eop_i[gnt_idx];
    data_o       = gnt_vld ? req_data_i[gnt_idx*FLIT_SIZE +: FLIT_SIZE] : '0;
    req_credit_o = credit_i ? grant_o : '0;
    eop_xfer     = tx_o && credit_i && eop_o;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          if (eop_xfer) begin
            rr_ptr_d = next_ptr(pick_idx);
          end else begin
            state_d = HOLD;
            gnt_d   = pick_idx;
          end
        end
      end
      HOLD: begin
        if (eop_xfer) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr(gnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

`ifdef DMNI_ARB_STATS_EN
  logic [STAT_W-1:0] pkt_cnt_q [N_REQ];
  logic [STAT_W-1:0] pkt_cnt_d [N_REQ];
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
      if (eop_xfer && (gnt_idx == PTR_W'(i))) pkt_cnt_d[i] = sat_inc(pkt_cnt_q[i]);
      pkt_cnt_o[i*STAT_W +: STAT_W] = pkt_cnt_q[i];
    end
    stall_cnt_d = (tx_o && !credit_i) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    stall_cnt_o = stall_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REQ; i++) pkt_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

`ifndef SYNTHESIS
  a_credit_onehot0 : assert property (@(posedge clk_i) $onehot0(req_credit_o));
`endif

endmodule
